debug_ram_loader: RTL and testbench

//   Synthesizable host-side driver for RV32Core debug BRAM ports (DataRAM/InstRAM A2/WD2/WE2/RD2) and core reset.

---
 rtl/debug_ram_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_debug_ram_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ram_loader.sv
// Byte-stream host loader: fills DataRAM/InstRAM debug ports,
// dumps them back as bytes, and pulses RV32Core reset on RUN.
//
// Ports:
//   CPU_CLK, CPU_RST_N        clock, async active-low reset
//   rx_data/rx_valid/rx_ready command + payload byte input
//   tx_data/tx_valid/tx_ready dump byte output
//   core_rst                  active-high reset to the core
//   dram_a2/wd2/we2/rd2       DataRAM debug port (1-cycle read)
//   iram_a2/wd2/we2/rd2       InstRAM debug port (1-cycle read)
//   busy                      state machine not idle
//   cmd_err                   sticky unknown-command flag
module debug_ram_loader #(
  parameter int unsigned BRAM_WORDS = 4096,
  parameter int unsigned RST_CYCLES = 5
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        core_rst,
  output logic [31:0] dram_a2,
  output logic [31:0] dram_wd2,
  output logic [3:0]  dram_we2,
  input  logic [31:0] dram_rd2,
  output logic [31:0] iram_a2,
  output logic [31:0] iram_wd2,
  output logic [3:0]  iram_we2,
  input  logic [31:0] iram_rd2,
  output logic        busy,
  output logic        cmd_err
);

  localparam int AW =
    (BRAM_WORDS > 1) ? $clog2(BRAM_WORDS) : 1;
  localparam int CW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX =
    AW'(BRAM_WORDS - 1);
  localparam logic [CW-1:0] LAST_RST =
    CW'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    LD_BYTE,
    LD_WRITE,
    DP_ADDR,
    DP_WAIT,
    DP_SEND,
    RUN_RST
  } state_e;

  state_e        state_q;
  logic          live_q;
  logic          iram_q;
  logic          dump_q;
  logic [7:0]    cnt_lo_q;
  logic [15:0]   left_q;
  logic [AW-1:0] widx_q;
  logic [1:0]    bidx_q;
  logic [31:0]   word_q;
  logic [CW-1:0] rst_cnt_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          core_rst_q;
  logic          cmd_err_q;
  logic [31:0]   dram_a2_q;
  logic [31:0]   dram_wd2_q;
  logic [3:0]    dram_we2_q;
  logic [31:0]   iram_a2_q;
  logic [31:0]   iram_wd2_q;
  logic [3:0]    iram_we2_q;

  logic          rx_fire;
  logic          tx_fire;
  logic [AW-1:0] widx_d;
  logic [31:0]   cur_addr;
  logic [31:0]   nxt_addr;
  logic [31:0]   rd_word;
  logic [31:0]   ld_word;
  logic [15:0]   cnt_d;

  // live_q keeps rx_ready low while reset is held
  assign rx_ready = live_q & (
    state_q == IDLE   || state_q == CNT_LO ||
    state_q == CNT_HI || state_q == LD_BYTE);
  assign busy     = (state_q != IDLE);
  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid_q & tx_ready;

  assign widx_d =
    (widx_q == LAST_IDX) ? '0 : widx_q + 1'b1;
  assign cur_addr = 32'({widx_q, 2'b00});
  assign nxt_addr = 32'({widx_d, 2'b00});
  assign rd_word  = iram_q ? iram_rd2 : dram_rd2;
  assign ld_word  = {rx_data, word_q[31:8]};
  assign cnt_d    = {rx_data, cnt_lo_q};

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign core_rst = core_rst_q;
  assign cmd_err  = cmd_err_q;
  assign dram_a2  = dram_a2_q;
  assign dram_wd2 = dram_wd2_q;
  assign dram_we2 = dram_we2_q;
  assign iram_a2  = iram_a2_q;
  assign iram_wd2 = iram_wd2_q;
  assign iram_we2 = iram_we2_q;

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q    <= IDLE;
      live_q     <= 1'b0;
      iram_q     <= 1'b0;
      dump_q     <= 1'b0;
      cnt_lo_q   <= '0;
      left_q     <= '0;
      widx_q     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      rst_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      core_rst_q <= 1'b1;
      cmd_err_q  <= 1'b0;
      dram_a2_q  <= '0;
      dram_wd2_q <= '0;
      dram_we2_q <= '0;
      iram_a2_q  <= '0;
      iram_wd2_q <= '0;
      iram_we2_q <= '0;
    end else begin
      live_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            unique case (rx_data)
              8'h01, 8'h02, 8'h04, 8'h05: begin
                iram_q <= (rx_data == 8'h02) ||
                          (rx_data == 8'h05);
                dump_q     <= rx_data[2];
                core_rst_q <= 1'b1;
                state_q    <= CNT_LO;
              end
              8'h03: begin
                core_rst_q <= 1'b1;
                rst_cnt_q  <= '0;
                state_q    <= RUN_RST;
              end
              default: cmd_err_q <= 1'b1;
            endcase
          end
        end
        CNT_LO: begin
          if (rx_fire) begin
            cnt_lo_q <= rx_data;
            state_q  <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (rx_fire) begin
            left_q <= cnt_d;
            widx_q <= '0;
            bidx_q <= '0;
            if (cnt_d == 16'd0) begin
              state_q <= IDLE;
            end else if (dump_q) begin
              if (iram_q) iram_a2_q <= '0;
              else        dram_a2_q <= '0;
              state_q <= DP_ADDR;
            end else begin
              state_q <= LD_BYTE;
            end
          end
        end
        LD_BYTE: begin
          if (rx_fire) begin
            // bytes shift in from the top: LSB-first word
            word_q <= ld_word;
            bidx_q <= bidx_q + 1'b1;
            if (bidx_q == 2'd3) begin
              if (iram_q) begin
                iram_a2_q  <= cur_addr;
                iram_wd2_q <= ld_word;
                iram_we2_q <= 4'hF;
              end else begin
                dram_a2_q  <= cur_addr;
                dram_wd2_q <= ld_word;
                dram_we2_q <= 4'hF;
              end
              state_q <= LD_WRITE;
            end
          end
        end
        LD_WRITE: begin
          dram_we2_q <= '0;
          iram_we2_q <= '0;
          widx_q     <= widx_d;
          left_q     <= left_q - 1'b1;
          state_q    <= (left_q == 16'd1) ? IDLE : LD_BYTE;
        end
        DP_ADDR: state_q <= DP_WAIT;
        DP_WAIT: begin
          word_q     <= rd_word;
          tx_data_q  <= rd_word[7:0];
          tx_valid_q <= 1'b1;
          bidx_q     <= '0;
          state_q    <= DP_SEND;
        end
        DP_SEND: begin
          if (tx_fire) begin
            if (bidx_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              widx_q     <= widx_d;
              left_q     <= left_q - 1'b1;
              if (left_q == 16'd1) begin
                state_q <= IDLE;
              end else begin
                if (iram_q) iram_a2_q <= nxt_addr;
                else        dram_a2_q <= nxt_addr;
                state_q <= DP_ADDR;
              end
            end else begin
              bidx_q    <= bidx_q + 1'b1;
              tx_data_q <= word_q[15:8];
              word_q    <= {8'h00, word_q[31:8]};
            end
          end
        end
        RUN_RST: begin
          if (rst_cnt_q == LAST_RST) begin
            core_rst_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ram_loader.sv
// Directed bench for debug_ram_loader with behavioural
// BRAM models on both debug ports.
module tb_debug_ram_loader;

  localparam int BW = 4;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        core_rst;
  logic [31:0] dram_a2, dram_wd2, dram_rd2;
  logic [3:0]  dram_we2;
  logic [31:0] iram_a2, iram_wd2, iram_rd2;
  logic [3:0]  iram_we2;
  logic        busy;
  logic        cmd_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] dmem [BW];
  logic [31:0] imem [BW];
  int  dwe_cnt = 0, iwe_cnt = 0, we_bad = 0;
  int  addr_err = 0, stab_err = 0;
  bit  rand_en = 0;
  logic [7:0] txq [$];
  logic       pv, pr;
  logic [7:0] pd;

  debug_ram_loader #(
    .BRAM_WORDS(BW),
    .RST_CYCLES(5)
  ) dut (
    .CPU_CLK(CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .core_rst(core_rst),
    .dram_a2(dram_a2),
    .dram_wd2(dram_wd2),
    .dram_we2(dram_we2),
    .dram_rd2(dram_rd2),
    .iram_a2(iram_a2),
    .iram_wd2(iram_wd2),
    .iram_we2(iram_we2),
    .iram_rd2(iram_rd2),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  initial begin
    for (int i = 0; i < BW; i++) begin
      dmem[i] = '0;
      imem[i] = '0;
    end
    dram_rd2 = '0;
    iram_rd2 = '0;
  end

  always @(posedge CPU_CLK) begin
    int di, ii;
    di = int'(dram_a2 >> 2);
    ii = int'(iram_a2 >> 2);
    if (dram_we2 != 4'h0) begin
      if (di < BW) dmem[di] <= dram_wd2;
      else addr_err++;
    end
    if (iram_we2 != 4'h0) begin
      if (ii < BW) imem[ii] <= iram_wd2;
      else addr_err++;
    end
    dram_rd2 <= (di < BW) ? dmem[di] : 32'hxxxxxxxx;
    iram_rd2 <= (ii < BW) ? imem[ii] : 32'hxxxxxxxx;
  end

  always @(negedge CPU_CLK) begin
    if (dram_we2 !== 4'h0) begin
      dwe_cnt++;
      if (dram_we2 !== 4'hF) we_bad++;
    end
    if (iram_we2 !== 4'h0) begin
      iwe_cnt++;
      if (iram_we2 !== 4'hF) we_bad++;
    end
    if (pv && !pr && CPU_RST_N &&
        (tx_valid !== 1'b1 || tx_data !== pd))
      stab_err++;
    if (tx_valid === 1'b1 && tx_ready)
      txq.push_back(tx_data);
    pv = tx_valid;
    pr = tx_ready;
    pd = tx_data;
  end

  initial begin
    forever begin
      @(posedge CPU_CLK);
      #1;
      tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    @(negedge CPU_CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rx_ready) begin
        @(posedge CPU_CLK);
        #1;
        ok = 1;
        break;
      end
      @(negedge CPU_CLK);
    end
    rx_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL rx_accept byte=%h not accepted", b);
    end
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge CPU_CLK);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    total_cnt++;
    if (!ok) $display("FAIL wait_idle busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    CPU_RST_N = 1'b0;
    repeat (2) @(negedge CPU_CLK);
    total_cnt++;
    if ({core_rst, busy, tx_valid, rx_ready, cmd_err}
        !== 5'b10000)
      $display("FAIL reset_outs got=%b want=10000",
        {core_rst, busy, tx_valid, rx_ready, cmd_err});
    else pass_cnt++;
    total_cnt++;
    if ({dram_we2, iram_we2} !== 8'h00)
      $display("FAIL reset_we got=%h want 00",
        {dram_we2, iram_we2});
    else pass_cnt++;
    CPU_RST_N = 1'b1;
    @(negedge CPU_CLK);
    total_cnt++;
    if (rx_ready !== 1'b1)
      $display("FAIL rx_ready_after_rst got=%b want 1",
        rx_ready);
    else pass_cnt++;
  endtask

  task automatic test_load_dram;
    logic [7:0] s [11];
    s = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34,
          8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    dwe_cnt = 0;
    iwe_cnt = 0;
    foreach (s[i]) send_byte(s[i]);
    wait_idle(20);
    total_cnt++;
    if (dmem[0] !== 32'h12345678)
      $display("FAIL dram0 got=%h want 12345678", dmem[0]);
    else pass_cnt++;
    total_cnt++;
    if (dmem[1] !== 32'hDEADBEEF)
      $display("FAIL dram1 got=%h want deadbeef", dmem[1]);
    else pass_cnt++;
    total_cnt++;
    if (dwe_cnt !== 2 || iwe_cnt !== 0 || we_bad !== 0)
      $display("FAIL load_we d=%0d i=%0d bad=%0d want 2 0 0",
        dwe_cnt, iwe_cnt, we_bad);
    else pass_cnt++;
    total_cnt++;
    if (core_rst !== 1'b1)
      $display("FAIL load_core_rst got=%b want 1", core_rst);
    else pass_cnt++;
  endtask

  task automatic test_zero_and_err;
    bit idle_seen;
    iwe_cnt = 0;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    idle_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CPU_CLK);
      if (!busy) begin
        idle_seen = 1;
        break;
      end
    end
    total_cnt++;
    if (!idle_seen || iwe_cnt !== 0)
      $display("FAIL zero_load idle=%b iwe=%0d want 1 0",
        idle_seen, iwe_cnt);
    else pass_cnt++;
    total_cnt++;
    if (cmd_err !== 1'b0)
      $display("FAIL cmd_err_pre got=%b want 0", cmd_err);
    else pass_cnt++;
    send_byte(8'h07);
    @(negedge CPU_CLK);
    total_cnt++;
    if (cmd_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_cmd err=%b busy=%b want 1 0",
        cmd_err, busy);
    else pass_cnt++;
  endtask

  task automatic test_run;
    int hi;
    logic [7:0] s [7];
    s = '{8'h02, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    foreach (s[i]) send_byte(s[i]);
    wait_idle(20);
    total_cnt++;
    if (imem[0] !== 32'h00000013)
      $display("FAIL iram0 got=%h want 00000013", imem[0]);
    else pass_cnt++;
    send_byte(8'h03);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CPU_CLK);
      if (core_rst) hi++;
      else break;
    end
    total_cnt++;
    if (hi !== 5)
      $display("FAIL run_pulse got=%0d want 5 cycles", hi);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || core_rst !== 1'b0)
      $display("FAIL run_end busy=%b rst=%b want 0 0",
        busy, core_rst);
    else pass_cnt++;
  endtask

  task automatic test_dump;
    logic [7:0] exp [8];
    exp = '{8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    txq.delete();
    stab_err = 0;
    rand_en = 1;
    send_byte(8'h04);
    send_byte(8'h02);
    send_byte(8'h00);
    wait_idle(2000);
    repeat (5) @(negedge CPU_CLK);
    rand_en = 0;
    total_cnt++;
    if (txq.size() !== 8)
      $display("FAIL dump_len got=%0d want 8", txq.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= txq.size())
        $display("FAIL dump_byte%0d got=none want %h",
          i, exp[i]);
      else if (txq[i] !== exp[i])
        $display("FAIL dump_byte%0d got=%h want %h",
          i, txq[i], exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stab_err !== 0 || core_rst !== 1'b1)
      $display("FAIL dump_hold stab=%0d rst=%b want 0 1",
        stab_err, core_rst);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] s [7];
    dwe_cnt = 0;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b0;
    #1;
    total_cnt++;
    if ({busy, core_rst, rx_ready, tx_valid} !== 4'b0100)
      $display("FAIL mid_rst got=%b want 0100",
        {busy, core_rst, rx_ready, tx_valid});
    else pass_cnt++;
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    repeat (3) @(negedge CPU_CLK);
    total_cnt++;
    if (dwe_cnt !== 0 || dmem[0] !== 32'h12345678)
      $display("FAIL mid_rst_nowr we=%0d d0=%h want 0 12345678",
        dwe_cnt, dmem[0]);
    else pass_cnt++;
    s = '{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (s[i]) send_byte(s[i]);
    wait_idle(20);
    total_cnt++;
    if (dmem[0] !== 32'h44332211 || dwe_cnt !== 1)
      $display("FAIL fresh_load d0=%h we=%0d want 44332211 1",
        dmem[0], dwe_cnt);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    dwe_cnt = 0;
    addr_err = 0;
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h00);
    for (int w = 1; w <= 5; w++)
      for (int b = 0; b < 4; b++)
        send_byte(8'(w * 8'h11));
    wait_idle(20);
    total_cnt++;
    if (dmem[0] !== 32'h55555555 || dmem[1] !== 32'h22222222)
      $display("FAIL wrap d0=%h d1=%h want 55555555 22222222",
        dmem[0], dmem[1]);
    else pass_cnt++;
    total_cnt++;
    if (dmem[3] !== 32'h44444444 || dwe_cnt !== 5 ||
        addr_err !== 0)
      $display("FAIL wrap_addr d3=%h we=%0d aerr=%0d want 44444444 5 0",
        dmem[3], dwe_cnt, addr_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_dram();
    test_zero_and_err();
    test_run();
    test_dump();
    test_reset_mid_load();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout global bound reached");
    $fatal(1);
  end

endmodule
